// File: rtl/microwave_ctrl.sv
// microwave_ctrl: keypad entry, BCD countdown and magnetron control for a microwave oven
// Inputs: clk, resetn (async, active-low), BCD_IN/loadn keypad digit and strobe,
//   pgt_1hz seconds tick, startn/stopn/clearn buttons (active-low), door_closed.
// Outputs: min_ones/sec_tens/sec_ones BCD time, mag_on, enablen (keypad enable), done.
module microwave_ctrl (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] BCD_IN,
  input  logic       loadn,
  input  logic       pgt_1hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       mag_on,
  output logic       enablen,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, COOK, PAUSE, DONE} state_t;
  state_t     state_q, state_d;
  logic [3:0] min_q, min_d, tens_q, tens_d, ones_q, ones_d;
  logic       loadn_q, pgt_q, startn_q, stopn_q, clearn_q, armed_q;
  logic       mag_on_q, enablen_q, done_q;
  logic       key_ev, tick_ev, start_ev, stop_ev, clr_ev, is_zero, is_one, can_start;
  // armed_q masks the first edge after reset so no event is taken before the second edge
  assign key_ev    = armed_q & loadn_q & ~loadn;
  assign tick_ev   = armed_q & ~pgt_q & pgt_1hz;
  assign start_ev  = armed_q & startn_q & ~startn;
  assign stop_ev   = armed_q & stopn_q & ~stopn;
  assign clr_ev    = armed_q & clearn_q & ~clearn;
  assign is_zero   = {min_q, tens_q, ones_q} == 12'h000;
  assign is_one    = {min_q, tens_q, ones_q} == 12'h001;
  assign can_start = door_closed & ~is_zero;
  assign min_ones  = min_q;
  assign sec_tens  = tens_q;
  assign sec_ones  = ones_q;
  assign mag_on    = mag_on_q;
  assign enablen   = enablen_q;
  assign done      = done_q;
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    case (state_q)
      IDLE: begin
        if (clr_ev) begin
          min_d  = 4'd0;
          tens_d = 4'd0;
          ones_d = 4'd0;
        end else if (!stop_ev && start_ev) begin
          state_d = can_start ? COOK : IDLE;
        end else if (!stop_ev && key_ev && BCD_IN <= 4'd9) begin
          min_d  = tens_q;
          tens_d = ones_q;
          ones_d = BCD_IN;
        end
      end
      COOK: begin
        // clear is not accepted while cooking but still outranks the tick
        if (stop_ev || !door_closed) begin
          state_d = PAUSE;
        end else if (!clr_ev && tick_ev) begin
          if (is_one) begin
            ones_d  = 4'd0;
            state_d = DONE;
          end else if (ones_q != 4'd0) begin
            ones_d = ones_q - 4'd1;
          end else begin
            ones_d = 4'd9;
            tens_d = (tens_q != 4'd0) ? tens_q - 4'd1 : 4'd5;
            min_d  = (tens_q != 4'd0) ? min_q : min_q - 4'd1;
          end
        end
      end
      PAUSE: begin
        if (clr_ev) begin
          state_d = IDLE;
          min_d   = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
        end else if (!stop_ev && start_ev && can_start) begin
          state_d = COOK;
        end
      end
      default: state_d = clr_ev ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      min_q     <= 4'd0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      mag_on_q  <= 1'b0;
      enablen_q <= 1'b0;
      done_q    <= 1'b0;
      loadn_q   <= 1'b1;
      pgt_q     <= 1'b0;
      startn_q  <= 1'b1;
      stopn_q   <= 1'b1;
      clearn_q  <= 1'b1;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      mag_on_q  <= state_d == COOK;
      enablen_q <= state_d != IDLE;
      done_q    <= state_d == DONE;
      loadn_q   <= loadn;
      pgt_q     <= pgt_1hz;
      startn_q  <= startn;
      stopn_q   <= stopn;
      clearn_q  <= clearn;
      armed_q   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_microwave_ctrl.sv
// tb_microwave_ctrl: directed bench for microwave_ctrl with a seconds-based reference model
module tb_microwave_ctrl;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] bcd = 4'd5;
  logic       loadn = 1'b0, pgt = 1'b0, startn = 1'b1, stopn = 1'b1, clearn = 1'b1, door = 1'b1;
  logic [3:0] min_ones, sec_tens, sec_ones;
  logic       mag_on, enablen, done;
  int         checks = 0, failures = 0;
  int         mst, mm, ms;
  logic       armed, pl, pst, psp, pc, pg;
  microwave_ctrl dut (
    .clk(clk), .resetn(resetn), .BCD_IN(bcd), .loadn(loadn), .pgt_1hz(pgt),
    .startn(startn), .stopn(stopn), .clearn(clearn), .door_closed(door),
    .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .mag_on(mag_on), .enablen(enablen), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask
  task automatic chk_t(input string n, input logic [11:0] e);
    chk(n, {min_ones, sec_tens, sec_ones}, e);
  endtask
  task automatic chk_f(input string n, input logic [2:0] e);
    chk(n, {mag_on, done, enablen}, e);
  endtask
  // model: state 0 idle, 1 cook, 2 pause, 3 done; time held as minutes and a 0..99 seconds field
  always @(posedge clk or negedge resetn) begin : mdl
    int st, m, s;
    logic k, go, sp, cl, tk;
    if (!resetn) begin
      mst <= 0; mm <= 0; ms <= 0; armed <= 1'b0;
      pl <= 1'b1; pst <= 1'b1; psp <= 1'b1; pc <= 1'b1; pg <= 1'b0;
    end else begin
      st = mst; m = mm; s = ms;
      k  = armed && pl && !loadn;
      go = armed && pst && !startn;
      sp = armed && psp && !stopn;
      cl = armed && pc && !clearn;
      tk = armed && !pg && pgt;
      case (st)
        0: if (cl) begin m = 0; s = 0; end
           else if (!sp && go) begin if (door && m + s > 0) st = 1; end
           else if (!sp && k && bcd <= 9) begin m = s / 10; s = (s % 10) * 10 + int'(bcd); end
        1: if (sp || !door) st = 2;
           else if (!cl && tk) begin
             if (m == 0 && s == 1) begin s = 0; st = 3; end
             else if (s > 0) s = s - 1;
             else begin m = m - 1; s = 59; end
           end
        2: if (cl) begin st = 0; m = 0; s = 0; end
           else if (go && !sp && door && m + s > 0) st = 1;
        default: if (cl) st = 0;
      endcase
      mst <= st; mm <= m; ms <= s; armed <= 1'b1;
      pl <= loadn; pst <= startn; psp <= stopn; pc <= clearn; pg <= pgt;
    end
  end
  always @(negedge clk) begin
    if (resetn) begin
      chk("mag_on", mag_on, mst == 1);
      chk("done", done, mst == 3);
      chk("enablen", enablen, mst != 0);
      chk("min_ones", min_ones, mm);
      chk("sec_tens", sec_tens, ms / 10);
      chk("sec_ones", sec_ones, ms % 10);
    end
  end
  task automatic ev(input logic k, input logic [3:0] d, input logic s, input logic p, input logic c, input logic t);
    bcd = d; loadn = !k; startn = !s; stopn = !p; clearn = !c; pgt = t;
    @(negedge clk);
    loadn = 1'b1; startn = 1'b1; stopn = 1'b1; clearn = 1'b1; pgt = 1'b0;
    @(negedge clk);
  endtask
  task automatic key(input logic [3:0] d); ev(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic start_b; ev(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic stop_b;  ev(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic clear_b; ev(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0); endtask
  task automatic tick;    ev(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1); endtask
  initial begin
    #12;
    chk_t("rst_time", 12'h000);
    chk_f("rst_flags", 3'b000);
    @(negedge clk) resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk_t("held_key_after_reset", 12'h000);
    loadn = 1'b1;
    @(negedge clk);
    key(1); key(3); key(0);
    chk_t("keys_130", 12'h130);
    start_b;
    chk_f("cook_flags", 3'b101);
    tick;
    chk_t("tick_129", 12'h129);
    stop_b;
    chk_f("pause_flags", 3'b001);
    clear_b;
    chk_t("clear_in_pause", 12'h000);
    chk_f("idle_flags", 3'b000);
    key(1); key(0); key(0); start_b; tick;
    chk_t("tick_100_to_059", 12'h059);
    ev(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_t("clear_tick_cook_time", 12'h059);
    chk_f("clear_tick_cook_flags", 3'b101);
    stop_b; clear_b; key(0); key(1); start_b; tick;
    chk_t("tick_001_to_000", 12'h000);
    chk_f("done_flags", 3'b011);
    tick;
    chk_t("done_tick_hold", 12'h000);
    clear_b;
    chk_f("done_clear_idle", 3'b000);
    key(4); key(5); start_b;
    door = 1'b0;
    @(negedge clk);
    chk_f("door_open_pause", 3'b001);
    door = 1'b1;
    tick; tick; tick;
    chk_t("pause_frozen_045", 12'h045);
    start_b;
    chk_f("resume_cook", 3'b101);
    stop_b;
    ev(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_f("start_stop_in_pause", 3'b001);
    stop_b;
    chk_f("stop_in_pause", 3'b001);
    clear_b;
    chk_t("clear_to_zero", 12'h000);
    start_b;
    chk_f("start_at_zero", 3'b000);
    key(7);
    door = 1'b0;
    start_b;
    chk_f("start_door_open", 3'b000);
    door = 1'b1;
    key(12);
    chk_t("key_12_ignored", 12'h007);
    tick;
    chk_t("tick_in_idle", 12'h007);
    clear_b; key(9); key(9);
    chk_t("entry_099", 12'h099);
    start_b; tick;
    chk_t("tick_099", 12'h098);
    for (int i = 0; i < 9; i++) tick;
    chk_t("ticks_to_089", 12'h089);
    stop_b; clear_b; key(3); key(0); start_b;
    chk_f("cook_030", 3'b101);
    #3 resetn = 1'b0;
    #1;
    chk_f("async_reset_flags", 3'b000);
    chk_t("async_reset_time", 12'h000);
    @(negedge clk) resetn = 1'b1;
    repeat (2) @(negedge clk);
    chk_f("post_reset_idle", 3'b000);
    key(2);
    chk_t("post_reset_key", 12'h002);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
